// File: rtl/mem_wb_unit.sv
// Memory-access and write-back back end of the multi-cycle datapath.
// Accepts one execute result, performs an optional data-memory access and retires it.
module mem_wb_unit #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [5:0]    op_i,
  input  logic [4:0]    rd_i,
  input  logic [31:0]   alu_i,
  input  logic [31:0]   addr_i,
  input  logic          br_taken_i,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_ack,
  input  logic [31:0]   dmem_rdata,
  output logic          reg_update,
  output logic [4:0]    reg_addr_o,
  output logic [31:0]   reg_o,
  output logic          pc_load,
  output logic [31:0]   pc_o,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [5:0] OP_ALU_MAX = 6'b000101;
  localparam logic [5:0] OP_SW      = 6'b010000;
  localparam logic [5:0] OP_LW      = 6'b010001;
  localparam logic [5:0] OP_BEQ     = 6'b100000;
  localparam logic [5:0] OP_JMP     = 6'b100001;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [5:0]    r_op;
  logic [7:0]    r_timer;
  logic          r_req;
  logic          r_we;
  logic [AW-1:0] r_daddr;
  logic [31:0]   r_wdata;
  logic          r_reg_update;
  logic [4:0]    r_reg_addr;
  logic [31:0]   r_reg_data;
  logic          r_pc_load;
  logic [31:0]   r_pc;
  logic          r_done;
  logic          r_err;

  logic w_is_alu;
  logic w_is_ls;
  logic w_aligned;
  logic w_mem;
  logic w_misal;
  logic w_is_beq;
  logic w_is_jmp;
  logic w_tmo;

  assign w_is_alu  = (op_i <= OP_ALU_MAX);
  assign w_is_ls   = (op_i == OP_SW) || (op_i == OP_LW);
  assign w_aligned = (addr_i[1:0] == 2'b00);
  assign w_mem     = w_is_ls && w_aligned;
  assign w_misal   = w_is_ls && !w_aligned;
  assign w_is_beq  = (op_i == OP_BEQ);
  assign w_is_jmp  = (op_i == OP_JMP);
  assign w_tmo     = (r_timer == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_timer      <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_daddr      <= '0;
      r_wdata      <= '0;
      r_reg_update <= 1'b0;
      r_reg_addr   <= '0;
      r_reg_data   <= '0;
      r_pc_load    <= 1'b0;
      r_pc         <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // Strobes live only in the single WB cycle.
      r_done       <= 1'b0;
      r_reg_update <= 1'b0;
      r_pc_load    <= 1'b0;
      r_err        <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (ex_valid) begin
            r_op       <= op_i;
            r_reg_addr <= rd_i;
            r_state    <= S_WB;
            r_done     <= 1'b1;
            unique case (1'b1)
              w_is_alu: begin
                r_reg_update <= 1'b1;
                r_reg_data   <= alu_i;
              end
              w_mem: begin
                r_state <= S_MEM;
                r_done  <= 1'b0;
                r_req   <= 1'b1;
                r_we    <= (op_i == OP_SW);
                r_daddr <= addr_i[AW+1:2];
                r_wdata <= alu_i;
                r_timer <= '0;
              end
              w_misal: r_err <= 1'b1;
              w_is_beq: begin
                r_pc_load <= br_taken_i;
                r_pc      <= addr_i;
              end
              w_is_jmp: begin
                r_pc_load <= 1'b1;
                r_pc      <= addr_i;
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          // An ack in the timeout cycle still completes normally.
          if (dmem_ack) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= S_WB;
            r_done  <= 1'b1;
            if (r_op == OP_LW) begin
              r_reg_update <= 1'b1;
              r_reg_data   <= dmem_rdata;
            end
          end else if (w_tmo) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_state <= S_WB;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ex_ready   = (r_state == S_IDLE);
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_daddr;
  assign dmem_wdata = r_wdata;
  assign reg_update = r_reg_update;
  assign reg_addr_o = r_reg_addr;
  assign reg_o      = r_reg_data;
  assign pc_load    = r_pc_load;
  assign pc_o       = r_pc;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Randomized self-checking bench for mem_wb_unit.
// Expected results come from an instruction-level model of the retire rules.
module tb_mem_wb_unit;

  localparam int AW  = 10;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [5:0]    op_i = '0;
  logic [4:0]    rd_i = '0;
  logic [31:0]   alu_i = '0;
  logic [31:0]   addr_i = '0;
  logic          br_taken_i = 1'b0;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic          dmem_ack = 1'b0;
  logic [31:0]   dmem_rdata = '0;
  logic          reg_update;
  logic [4:0]    reg_addr_o;
  logic [31:0]   reg_o;
  logic          pc_load;
  logic [31:0]   pc_o;
  logic          done;
  logic          err;

  int checks = 0;
  int failures = 0;

  mem_wb_unit #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .op_i(op_i), .rd_i(rd_i), .alu_i(alu_i),
    .addr_i(addr_i), .br_taken_i(br_taken_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .reg_update(reg_update), .reg_addr_o(reg_addr_o),
    .reg_o(reg_o), .pc_load(pc_load), .pc_o(pc_o),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level view: what retiring this op must produce.
  task automatic model(input logic [5:0] op, input logic [31:0] alu,
                       input logic [31:0] addr, input logic br,
                       input int ack_at, input logic [31:0] rdata,
                       output int mc, output bit upd,
                       output logic [31:0] data, output bit pl,
                       output bit e);
    mc = 0; upd = 0; data = '0; pl = 0; e = 0;
    if (op <= 6'd5) begin
      upd = 1; data = alu;
    end else if (op == 6'd16 || op == 6'd17) begin
      if (addr % 4 != 0) e = 1;
      else if (ack_at >= 1 && ack_at <= TMO) begin
        mc = ack_at;
        if (op == 6'd17) begin upd = 1; data = rdata; end
      end else begin
        mc = TMO; e = 1;
      end
    end else if (op == 6'd32) pl = br;
    else if (op == 6'd33) pl = 1;
  endtask

  task automatic run(input logic [5:0] op, input logic [4:0] rd,
                     input logic [31:0] alu, input logic [31:0] addr,
                     input logic br, input int ack_at,
                     input logic [31:0] rdata);
    int mc;
    bit upd, pl, e;
    logic [31:0] data;
    logic [31:0] word;
    model(op, alu, addr, br, ack_at, rdata, mc, upd, data, pl, e);
    word = 32'(addr[AW+1:2]);
    chk("idle_ready", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1; op_i = op; rd_i = rd;
    alu_i = alu; addr_i = addr; br_taken_i = br;
    tick();
    ex_valid = 1'b0;
    op_i = 6'($urandom); rd_i = 5'($urandom);
    alu_i = $urandom; addr_i = $urandom; br_taken_i = 1'($urandom);
    for (int k = 1; k <= mc; k++) begin
      chk("mem_req", 32'(dmem_req), 32'd1);
      chk("mem_we", 32'(dmem_we), 32'(op == 6'd16));
      chk("mem_addr", 32'(dmem_addr), word);
      if (op == 6'd16) chk("mem_wdata", dmem_wdata, alu);
      chk("mem_done", 32'(done), 32'd0);
      chk("mem_ready", 32'(ex_ready), 32'd0);
      dmem_ack = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rdata : $urandom;
      tick();
    end
    dmem_ack = 1'b0;
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_err", 32'(err), 32'(e));
    chk("wb_upd", 32'(reg_update), 32'(upd));
    chk("wb_pcld", 32'(pc_load), 32'(pl));
    chk("wb_req", 32'(dmem_req), 32'd0);
    chk("wb_ready", 32'(ex_ready), 32'd0);
    if (upd) begin
      chk("wb_rd", 32'(reg_addr_o), 32'(rd));
      chk("wb_data", reg_o, data);
    end
    if (pl) chk("wb_pc", pc_o, addr);
    tick();
    chk("post_done", 32'(done), 32'd0);
    chk("post_ready", 32'(ex_ready), 32'd1);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [10];
    ops = '{6'd0, 6'd3, 6'd5, 6'd16, 6'd17, 6'd16,
            6'd17, 6'd32, 6'd33, 6'd0};
    if ($urandom_range(0, 9) == 0) return 6'($urandom);
    return ops[$urandom_range(0, 9)];
  endfunction

  initial begin
    logic [31:0] a;
    tick();
    tick();
    chk("rst_ready", 32'(ex_ready), 32'd1);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_upd", 32'(reg_update), 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    // Reset must beat a valid request.
    ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    chk("rst_win_ready", 32'(ex_ready), 32'd1);
    rst = 1'b0;
    tick();
    chk("rst_win_done", 32'(done), 32'd0);

    run(6'd0, 5'd3, 32'h5, 32'h0, 1'b0, 0, 32'h0);
    run(6'd16, 5'd7, 32'hDEADBEEF, 32'h10, 1'b0, 3, 32'h0);
    run(6'd17, 5'd9, 32'h0, 32'h8, 1'b0, 1, 32'h12345678);
    run(6'd32, 5'd1, 32'h0, 32'h80, 1'b0, 0, 32'h0);
    run(6'd33, 5'd1, 32'h0, 32'h40, 1'b0, 0, 32'h0);
    run(6'd17, 5'd2, 32'h0, 32'h6, 1'b0, 1, 32'h0);
    run(6'd17, 5'd2, 32'h0, 32'h20, 1'b0, 0, 32'hAAAA5555);
    run(6'd17, 5'd0, 32'h0, 32'h24, 1'b0, TMO, 32'hCAFEF00D);
    run(6'd32, 5'd4, 32'h0, 32'h100, 1'b1, 0, 32'h0);
    run(6'd63, 5'd4, 32'h0, 32'h100, 1'b1, 0, 32'h0);

    // Reset while waiting in MEM.
    ex_valid = 1'b1; op_i = 6'd16; addr_i = 32'h30; alu_i = 32'h1;
    tick();
    ex_valid = 1'b0;
    tick();
    chk("mrst_req_pre", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_req", 32'(dmem_req), 32'd0);
    chk("mrst_ready", 32'(ex_ready), 32'd1);
    chk("mrst_done", 32'(done), 32'd0);
    tick();
    chk("mrst_done2", 32'(done), 32'd0);
    run(6'd2, 5'd31, 32'h77, 32'h0, 1'b0, 0, 32'h0);

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run(pick_op(), 5'($urandom), $urandom, a, 1'($urandom),
          $urandom_range(0, TMO + 1), $urandom);
      // Stray acks while idle must be ignored.
      for (int g = 0; g < $urandom_range(0, 2); g++) begin
        dmem_ack = 1'($urandom);
        tick();
        dmem_ack = 1'b0;
        chk("idle_ack_done", 32'(done), 32'd0);
        chk("idle_ack_req", 32'(dmem_req), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
- Back end of the multi-cycle datapath: consumes the execute stage's result (op, alu result, computed address, branch flag, destination register).
- Performs the data-memory access for SW/LW through a req/ack handshake.
- Resolves BEQ/JMP into a PC load and drives the register-file write-back (reg_update / reg data) toward the register file.

Parameters:
- AW, 10, data-memory word-address width; dmem_addr = addr_i[AW+1:2].
- TIMEOUT, 16, maximum cycles spent in MEM waiting for dmem_ack before an error abort; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute result valid.
- ex_ready  out  1  unit can accept (high only in IDLE).
- op_i  in  6  opcode [31:26] of the instruction.
- rd_i  in  5  destination/source register index (instr [25:21]).
- alu_i  in  32  ALU result, or store data for SW.
- addr_i  in  32  byte address (SW/LW) or branch/jump target.
- br_taken_i  in  1  BEQ condition true.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write (SW), 0 = read (LW).
- dmem_addr  out  AW  word address.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  memory completes (rdata valid on the same cycle for reads).
- dmem_rdata  in  32  load data.
- reg_update  out  1  register write strobe (1 cycle).
- reg_addr_o  out  5  register index to write.
- reg_o  out  32  write-back data.
- pc_load  out  1  PC overwrite strobe (1 cycle).
- pc_o  out  32  new PC.
- done  out  1  instruction retired (1 cycle).
- err  out  1  misaligned access or timeout (1 cycle, coincident with done).

Behaviour:
- Reset: state IDLE; all outputs 0 except ex_ready = 1; timer 0.
  - Reset wins over every other event.
  - Reset in MEM drops dmem_req at that edge; no write-back, no done.
- FSM states: IDLE, MEM, WB.
- IDLE, ex_valid = 1: latch op/rd/alu/addr/br_taken at the edge.
  - ALU ops 000000..000101 -> WB with write-back of alu_i.
  - SW 010000 or LW 010001 with addr_i[1:0] == 0 -> MEM. dmem_req = 1, dmem_we = (op == SW), dmem_addr, dmem_wdata registered at the same edge.
  - SW/LW with addr_i[1:0] != 0 -> WB with err; no memory access, no write-back.
  - BEQ 100000 -> WB; pc_load = br_taken_i, pc_o = addr_i.
  - JMP 100001 -> WB; pc_load = 1, pc_o = addr_i.
  - Any other opcode -> WB, no side effects (done only).
- MEM:
  - dmem_req, we, addr, wdata held stable until the cycle dmem_ack is sampled high.
  - Ack sampled: deassert req at that edge. LW captures dmem_rdata as write-back data; SW has no write-back. -> WB.
  - Timer increments each MEM cycle without ack. On reaching TIMEOUT: deassert req -> WB with err, no write-back. An ack arriving in the same cycle as the timeout wins (normal completion).
  - dmem_ack outside MEM is ignored.
- WB: exactly one cycle, then IDLE.
  - done = 1.
  - reg_update / pc_load / err per the decode above.
  - reg_addr_o, reg_o, pc_o valid this cycle.
  - reg_update is never 1 together with pc_load.
- Latency, measured from the accept edge to the done cycle:
  - ALU/branch/jump/no-op/misaligned: 1 cycle.
  - Memory: 1 + (MEM cycles); minimum 2, when ack arrives in the first MEM cycle.
- Throughput: one instruction at a time; ex_ready = 0 in MEM and WB, so back-to-back accepts are 2 cycles apart minimum.
- reg_addr_o = rd_i for all write-backs. Register 0 is written like any other (no hard-wired zero).

Test Plan:
- Reset, then op = 000000, rd = 3, alu_i = 0x0000_0005 -> next cycle: done = 1, reg_update = 1, reg_addr_o = 3, reg_o = 5, pc_load = 0.
- SW, addr_i = 0x0000_0010, alu_i = 0xDEAD_BEEF, ack on 3rd MEM cycle -> dmem_req high 3 cycles, dmem_we = 1, dmem_addr = 4, wdata stable throughout; then done with reg_update = 0.
- LW, addr_i = 0x8, dmem_rdata = 0x1234_5678 with ack in 1st MEM cycle -> done 2 cycles after accept, reg_update = 1, reg_o = 0x1234_5678.
- BEQ br_taken = 0, then JMP addr_i = 0x40 -> first: done, pc_load = 0; second: pc_load = 1, pc_o = 0x40.
- LW addr_i = 0x6 -> no dmem_req, done + err next cycle. LW aligned with ack never, TIMEOUT = 4 -> req high 4 cycles, then done + err, reg_update = 0.
- Reset asserted during MEM -> dmem_req = 0 and ex_ready = 1 after that edge, no done. A subsequent ALU op completes normally.
